instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters: BASE_ADDR, default 32'h0000_0000, first instruction-memory byte address; LIMIT, default 64, words written before DONE; DEPTH, fixed 4, buffer entries.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; IDLE->RUN, DONE->RUN restart.
REQ-005 in_valid  input  1  field set presented.
REQ-006 in_ready  output  1  encoder accepts field set this cycle.
REQ-007 cond  input  4  condition field, instr[31:28].
REQ-008 op  input  2  instr[27:26].
REQ-009 funct  input  6  instr[25:20] (DP/mem).
REQ-010 rn, rd  input  4 each  instr[19:16], instr[15:12].
REQ-011 src2  input  12  instr[11:0].
REQ-012 mem_stall  input  1  memory cannot take a write this cycle.
REQ-013 mem_we  output  1  registered write strobe.
REQ-014 mem_addr  output  32  registered byte address.
REQ-015 mem_wd  output  32  registered encoded instruction.
REQ-016 done  output  1  high in DONE state.
REQ-017 count  output  3  buffer occupancy, 0..4.

Function
REQ-018 Handshake: transfer when in_valid && in_ready, with in_ready = (count < 4) && state != DONE, independent of in_valid.
REQ-019 op 00/01: word = {cond, op, funct, rn, rd, src2}.
REQ-020 op 10: word = {cond, 2'b10, 2'b10, funct[3:0], rn, rd, src2}; funct[5:4] ignored.
REQ-021 Encoded words enter a 4-entry FIFO in acceptance order.
REQ-022 States: IDLE, RUN, DONE; reset enters IDLE.
REQ-023 IDLE: accepts into FIFO, no writes; start -> RUN.
REQ-024 RUN: pop head when count > 0 && !mem_stall; next cycle mem_we=1, mem_addr=current address, mem_wd=head; address += 4, written += 1.
REQ-025 Latency: word accepted in cycle N with empty FIFO, RUN, no stall -> mem_we high in cycle N+1.
REQ-026 mem_we is low in every cycle not following a pop; mem_addr/mem_wd hold their last values when mem_we is low.
REQ-027 Simultaneous push and pop: count unchanged; push into full FIFO never occurs because in_ready=0.
REQ-028 When written reaches LIMIT after a pop -> DONE; no further pops; remaining FIFO contents retained.
REQ-029 DONE: done=1, in_ready=0; start -> address=BASE_ADDR, written=0, RUN.
REQ-030 start in RUN ignored.
REQ-031 Address increments modulo 2^32; wrap permitted, not flagged.

Reset
REQ-032 reset=0 at a rising edge: state=IDLE, count=0, FIFO pointers=0, address=BASE_ADDR, written=0, mem_we=0, mem_addr=0, mem_wd=0, done=0.
REQ-033 Reset mid-RUN discards buffered and in-flight words; no mem_we in the cycle after reset.
REQ-034 in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-035 Macro ENC_CHECK_EN defined: a field set with op=11 is accepted (handshake completes) but not queued; output enc_err (1 bit) pulses high the next cycle; err_cnt (8 bits, saturating at 255, reset 0) increments.
REQ-036 ENC_CHECK_EN undefined: enc_err and err_cnt absent; op=11 encoded per REQ-019.

Verification
REQ-037 reset, start, push cond=E op=00 funct=101000 rn=2 rd=1 src2=005 -> next cycle mem_we=1, mem_addr=0x0, mem_wd=0xE2821005.
REQ-038 RUN, push op=01 funct=011001 rn=0 rd=3 src2=004 then op=10 cond=E all other fields 0 except src2=002 -> mem_wd 0xE5903004 at addr 0x0, then 0xEA000002 at addr 0x4, consecutive cycles.
REQ-039 IDLE, push 5 words -> in_ready low after 4th, count=4; start -> 4 writes at 0x0..0xC, 5th accepted once count drops.
REQ-040 RUN, mem_stall=1 for 3 cycles with count=2 -> no mem_we, count=2; stall release -> two writes in order.
REQ-041 LIMIT=2, push 3 words -> 2 writes, done=1, count=1, in_ready=0; start -> 3rd word written at BASE_ADDR.
REQ-042 ENC_CHECK_EN: push op=11 then valid op=00 -> enc_err pulse, err_cnt=1, only the op=00 word written.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-set input and instruction-memory write bus of the instruction encoder.
// The encoder connects through the slave modport; the producer/memory side
// (or a testbench) uses the master modport.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic        mem_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;

    modport master (
        output in_valid, cond, op, funct, rn, rd, src2, mem_stall,
        input  in_ready, mem_we, mem_addr, mem_wd
    );

    modport slave (
        input  in_valid, cond, op, funct, rn, rd, src2, mem_stall,
        output in_ready, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field sets into 32-bit instruction words, buffers
// them in a 4-entry FIFO and streams them into instruction memory starting at
// BASE_ADDR until LIMIT words are written.
// Optional build macro ENC_CHECK_EN: op=11 field sets are consumed but flagged
// on enc_err / counted in err_cnt instead of being encoded.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LIMIT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    instr_encoder_if.slave        bus,
    output logic                  done,
    output logic [2:0]            count
`ifdef ENC_CHECK_EN
    ,
    output logic                  enc_err,
    output logic [7:0]            err_cnt
`endif
);

    localparam int unsigned DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fifo_q [DEPTH];
    logic [31:0] fifo_d [DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] written_q, written_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        done_q, done_d;

    logic [31:0] enc_word;
    logic        accept;
    logic        push_ok;
    logic        pop;
    logic        bypass;
    logic [31:0] head_word;

`ifdef ENC_CHECK_EN
    logic        enc_err_q, enc_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
`endif

    // Pack the presented field set into an instruction word.
    always_comb begin
        if (bus.op == 2'b10) begin
            enc_word = {bus.cond, 2'b10, 2'b10, bus.funct[3:0], bus.rn, bus.rd, bus.src2};
        end else begin
            enc_word = {bus.cond, bus.op, bus.funct, bus.rn, bus.rd, bus.src2};
        end
    end

    assign bus.in_ready = (count_q < 3'(DEPTH)) && (state_q != S_DONE);
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef ENC_CHECK_EN
    assign push_ok = accept && (bus.op != 2'b11);
`else
    assign push_ok = accept;
`endif

    // Next-state logic for FSM, FIFO, address/word counters and write port.
    // A word accepted while the FIFO is empty in RUN goes straight to the
    // write port (bypass) so it is written the very next cycle; this is
    // the same as a push and pop on an empty FIFO, hence count stays 0.
    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        written_d  = written_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;

        pop       = (state_q == S_RUN) && !bus.mem_stall && ((count_q != 3'd0) || push_ok);
        bypass    = pop && (count_q == 3'd0);
        head_word = (count_q != 3'd0) ? fifo_q[rd_ptr_q] : enc_word;

        if (push_ok && !bypass) begin
            fifo_d[wr_ptr_q] = enc_word;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop && !bypass) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, (push_ok && !bypass)} - {2'b00, (pop && !bypass)};

        if (pop) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_wd_d   = head_word;
            addr_d     = addr_q + 32'd4;
            written_d  = written_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pop && (written_q + 32'd1 == LIMIT)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    addr_d    = BASE_ADDR;
                    written_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
    end

`ifdef ENC_CHECK_EN
    // Flag rejected op=11 field sets and keep a saturating tally.
    always_comb begin
        enc_err_d = 1'b0;
        err_cnt_d = err_cnt_q;
        if (accept && (bus.op == 2'b11)) begin
            enc_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Error flag/counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enc_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            enc_err_q <= enc_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign enc_err = enc_err_q;
    assign err_cnt = err_cnt_q;
`endif

    // Register FSM state, FIFO and all outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            written_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            written_q  <= written_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign done         = done_q;
    assign count        = count_q;

endmodule
